// File: rtl/rx_frame_check.sv
// UART RX frame checker: LSB-first deserialiser with optional parity, 1/2 stop bits,
// per-frame status and saturating error counters. Break detection enabled by RX_BREAK_DET_EN.
module rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frame_start,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  err_clr,
   output logic                  busy,
   output logic                  frame_done,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  par_err,
   output logic                  stp_err,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt,
   output logic                  brk_det
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [3:0]            bit_cnt;
   logic                  par_acc;
   logic                  par_fail;
   logic                  stp_fail;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  stp_inc;
`ifdef RX_BREAK_DET_EN
   logic                  all_zero;
   logic                  brk_q;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         data_out   <= '0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         shift_q    <= '0;
         bit_cnt    <= '0;
         par_acc    <= 1'b0;
         par_fail   <= 1'b0;
         stp_fail   <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
`ifdef RX_BREAK_DET_EN
         all_zero   <= 1'b0;
         brk_q      <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         // frame_start restarts from any state and discards a coincident strobe
         if (frame_start) begin
            state     <= DATA;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            par_fail  <= 1'b0;
            stp_fail  <= 1'b0;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
`ifdef RX_BREAK_DET_EN
            all_zero  <= 1'b1;
`endif
         end else if (bit_valid) begin
            case (state)
               DATA: begin
                  shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                  par_acc <= par_acc ^ sampled_bit;
`ifdef RX_BREAK_DET_EN
                  all_zero <= all_zero & ~sampled_bit;
`endif
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               PARITY: begin
                  par_fail <= sampled_bit ^ par_acc ^ par_typ_q;
`ifdef RX_BREAK_DET_EN
                  all_zero <= all_zero & ~sampled_bit;
`endif
                  state    <= STOP;
               end
               STOP: begin
                  if (!sampled_bit)
                     stp_fail <= 1'b1;
`ifdef RX_BREAK_DET_EN
                  if (bit_cnt == '0)
                     all_zero <= all_zero & ~sampled_bit;
`endif
                  if (bit_cnt == LAST_STOP) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     data_out   <= shift_q;
                     par_err    <= par_fail;
                     stp_err    <= stp_fail | ~sampled_bit;
`ifdef RX_BREAK_DET_EN
                     // only the first stop bit takes part in break detection
                     brk_q      <= all_zero & ((bit_cnt != '0) | ~sampled_bit);
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef RX_BREAK_DET_EN
   assign brk_det = brk_q;
   assign stp_inc = stp_err & ~brk_q;
`else
   assign brk_det = 1'b0;
   assign stp_inc = stp_err;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (err_clr) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (frame_done) begin
         if (par_err && par_err_cnt != '1)
            par_err_cnt <= par_err_cnt + 1'b1;
         if (stp_inc && stp_err_cnt != '1)
            stp_err_cnt <= stp_err_cnt + 1'b1;
      end
   end

endmodule
